// File: rtl/axi_ip_pkg.sv
// Shared constants and helpers for the decimator AXI-Stream output path.
package axi_ip_pkg;

  localparam int SAMPLE_W       = 16;
  localparam int AXIS_W         = 32;
  localparam int FRAME_LEN_DEF  = 256;
  localparam int FIFO_DEPTH_DEF = 16;

  typedef enum logic {
    PK_LOW  = 1'b0,
    PK_HIGH = 1'b1
  } pack_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // A counter that only ever holds 0 still needs one bit.
  function automatic int cnt_width(input int count);
    return (count <= 1) ? 1 : clog2(count);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push while full is taken when a pop
// frees the slot in the same cycle. rdata reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign level   = cnt;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/decim_axis_packer.sv
// Captures decimated samples on rising din_rdy, pairs them into 32-bit words and
// streams them out over AXI4-Stream with TLAST every FRAME_LEN beats.
//
// state   | meaning
// PK_LOW  | waiting for the earlier sample of a pair (lands in [15:0])
// PK_HIGH | holding lo_reg, next capture completes the word
module decim_axis_packer
  import axi_ip_pkg::*;
#(
  parameter int DATA_W     = SAMPLE_W,
  parameter int AXIS_W     = axi_ip_pkg::AXIS_W,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int FRAME_LEN  = FRAME_LEN_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [DATA_W-1:0]             din,
  input  logic                          din_rdy,
  output logic [AXIS_W-1:0]             m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          overflow,
  input  logic                          clr_ovf,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int BEAT_W = cnt_width(FRAME_LEN);

  pack_state_t         state;
  logic                din_rdy_d;
  logic                cap;
  logic [DATA_W-1:0]   lo_reg;
  logic [BEAT_W-1:0]   beat_cnt;
  logic                beat_last;
  logic                word_vld;
  logic [AXIS_W:0]     word_reg;
  logic [AXIS_W:0]     rd_word;
  logic                full;
  logic                empty;
  logic                pop;
  logic                drop;

  assign cap       = din_rdy & ~din_rdy_d & en;
  assign beat_last = (beat_cnt == BEAT_W'(FRAME_LEN - 1));

  // Completed words are registered once before the FIFO, giving capture-to-tvalid of 2 clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= PK_LOW;
      din_rdy_d <= 1'b0;
      lo_reg    <= '0;
      beat_cnt  <= '0;
      word_vld  <= 1'b0;
      word_reg  <= '0;
    end else begin
      din_rdy_d <= din_rdy;
      word_vld  <= 1'b0;
      if (!en) begin
        state    <= PK_LOW;
        lo_reg   <= '0;
        beat_cnt <= '0;
      end else if (cap) begin
        case (state)
          PK_LOW: begin
            lo_reg <= din;
            state  <= PK_HIGH;
          end
          PK_HIGH: begin
            word_vld <= 1'b1;
            word_reg <= {beat_last, din, lo_reg};
            // Dropped words still advance the beat so frames stay tied to sample time.
            beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
            state    <= PK_LOW;
          end
          default: state <= PK_LOW;
        endcase
      end
    end
  end

  assign pop  = m_axis_tvalid & m_axis_tready;
  assign drop = word_vld & full & ~pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  sync_fifo #(
    .WIDTH (AXIS_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (word_vld),
    .wdata (word_reg),
    .pop   (pop),
    .rdata (rd_word),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign m_axis_tvalid = ~empty;
  assign m_axis_tdata  = rd_word[AXIS_W-1:0];
  assign m_axis_tlast  = rd_word[AXIS_W];

endmodule

// File: tb/tb_decim_axis_packer.sv
// Directed bench for decim_axis_packer with an expected-beat queue fed at stimulus time.
module tb_decim_axis_packer;

  localparam int FL    = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] din;
  logic        din_rdy;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        overflow;
  logic        clr_ovf;
  logic [4:0]  level;

  int checks = 0;
  int failures = 0;

  logic [32:0] exp_q[$];
  bit          m_half;
  logic [15:0] m_lo;
  int          m_beat;
  bit          track_fill;
  int          m_fill;
  int          pops = 0;
  bit          rand_ready = 1'b0;

  always #5 clk = ~clk;

  decim_axis_packer #(
    .FIFO_DEPTH (DEPTH),
    .FRAME_LEN  (FL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .din           (din),
    .din_rdy       (din_rdy),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .overflow      (overflow),
    .clr_ovf       (clr_ovf),
    .level         (level)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_cap(input logic [15:0] v);
    logic [32:0] w;
    if (m_half) begin
      w = {(m_beat == FL - 1), v, m_lo};
      if (!(track_fill && m_fill >= DEPTH)) begin
        exp_q.push_back(w);
        if (track_fill) m_fill++;
      end
      m_beat = (m_beat == FL - 1) ? 0 : m_beat + 1;
      m_half = 1'b0;
    end else begin
      m_lo   = v;
      m_half = 1'b1;
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] v, input int hold, input int gap);
    din     = v;
    din_rdy = 1'b1;
    if (en) model_cap(v);
    tick(hold);
    din_rdy = 1'b0;
    din     = 16'h0;
    tick(gap);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_half = 1'b0;
    m_lo   = 16'h0;
    m_beat = 0;
    m_fill = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    tick(2);
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // Output monitor: stall stability plus in-order comparison against the queue.
  initial begin
    logic        prev_stall;
    logic [32:0] prev_w;
    logic [32:0] e;
    prev_stall = 1'b0;
    prev_w     = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_tvalid", 64'(tvalid), 64'd1);
          check("stall_hold", 64'({tlast, tdata}), 64'(prev_w));
        end
        if (tvalid && tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL unexpected_beat observed=%h expected=none", {tlast, tdata});
          end else begin
            e = exp_q.pop_front();
            check("beat", 64'({tlast, tdata}), 64'(e));
          end
          pops++;
        end
        prev_stall = tvalid & ~tready;
        prev_w     = {tlast, tdata};
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) tready = ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    logic [15:0] r;
    reset = 1'b1;
    en = 1'b1;
    din = 16'h0;
    din_rdy = 1'b0;
    tready = 1'b1;
    clr_ovf = 1'b0;
    track_fill = 1'b0;
    model_reset();
    tick(3);
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_tdata", 64'(tdata), 64'd0);
    check("rst_tlast", 64'(tlast), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    reset = 1'b0;
    tick();

    // 1: basic pair and capture-to-tvalid latency
    send(16'h1111, 1, 3);
    din = 16'h2222;
    din_rdy = 1'b1;
    model_cap(16'h2222);
    tick();
    check("t1_tvalid_early", 64'(tvalid), 64'd0);
    tick();
    check("t1_tvalid_2clk", 64'(tvalid), 64'd1);
    check("t1_tdata", 64'(tdata), 64'h2222_1111);
    din_rdy = 1'b0;
    tick(2);
    wait_drain("t1_drain");

    // 2: long din_rdy high is one capture
    send(16'h3333, 20, 2);
    check("t2_level", 64'(level), 64'd0);
    check("t2_tvalid", 64'(tvalid), 64'd0);
    send(16'h4444, 1, 3);
    wait_drain("t2_drain");

    // 3: frame tagging with FRAME_LEN=4
    do_reset();
    p0 = pops;
    for (int i = 0; i < 16; i++) send(16'h1000 + 16'(i), 1, 1);
    wait_drain("t3_drain");
    check("t3_beats", 64'(pops - p0), 64'd8);

    // 4: fill, overflow, drain, frame alignment after drop
    do_reset();
    tready = 1'b0;
    track_fill = 1'b1;
    for (int i = 0; i < 34; i++) send(16'h2000 + 16'(i), 1, 1);
    tick(2);
    check("t4_level_full", 64'(level), 64'd16);
    check("t4_overflow", 64'(overflow), 64'd1);
    check("t4_tvalid", 64'(tvalid), 64'd1);
    tready = 1'b1;
    wait_drain("t4_drain");
    track_fill = 1'b0;
    tick(2);
    check("t4_level_empty", 64'(level), 64'd0);
    check("t4_ovf_sticky", 64'(overflow), 64'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("t4_ovf_clear", 64'(overflow), 64'd0);
    for (int i = 0; i < 8; i++) send(16'h2100 + 16'(i), 1, 1);
    wait_drain("t4_realign");

    // 5: random tready stalls
    do_reset();
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      r = 16'($urandom);
      send(r, 1, 3);
    end
    wait_drain("t5_drain");
    rand_ready = 1'b0;
    tready = 1'b1;
    tick(2);
    check("t5_overflow", 64'(overflow), 64'd0);
    check("t5_level", 64'(level), 64'd0);

    // 6: en drop discards half pair, then reset mid-stream
    do_reset();
    send(16'h5555, 1, 2);
    en = 1'b0;
    m_half = 1'b0;
    m_lo = 16'h0;
    m_beat = 0;
    tick(2);
    send(16'h7777, 1, 1);
    en = 1'b1;
    tick();
    send(16'hAAAA, 1, 1);
    send(16'hBBBB, 1, 3);
    wait_drain("t6_drain");
    tready = 1'b0;
    for (int i = 0; i < 4; i++) send(16'h6000 + 16'(i), 1, 1);
    tick(2);
    check("t6_level_pre", 64'(level), 64'd2);
    reset = 1'b1;
    model_reset();
    tick();
    check("t6_rst_tvalid", 64'(tvalid), 64'd0);
    check("t6_rst_level", 64'(level), 64'd0);
    reset = 1'b0;
    tready = 1'b1;
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
